pp_accum_mult: RTL and testbench

PP_ACCUM_MULT -- requirements
Module: pp_accum_mult

---
 rtl/pp_accum_mult.sv | 192 +++++++++++++++++++
 tb/tb_pp_accum_mult.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pp_accum_mult.sv
// Sequential unsigned multiplier: one partial-product row is accumulated per
// cycle through a ripple adder built from half/full-adder cells.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ ci;
  assign c = (x & y) | (ci & (x ^ y));
endmodule

module pp_ripple_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum
);
  logic [W-2:0] carry;
  // The product always fits in W bits, so the top carry is never needed.
  logic         carry_out_unused;

  half_adder u_ha0 (
    .x (x[0]),
    .y (y[0]),
    .s (sum[0]),
    .c (carry[0])
  );

  genvar i;
  generate
    for (i = 1; i < W; i++) begin : g_bit
      if (i < W - 1) begin : g_mid
        full_adder u_fa (
          .x  (x[i]),
          .y  (y[i]),
          .ci (carry[i-1]),
          .s  (sum[i]),
          .c  (carry[i])
        );
      end else begin : g_top
        full_adder u_fa (
          .x  (x[i]),
          .y  (y[i]),
          .ci (carry[i-1]),
          .s  (sum[i]),
          .c  (carry_out_unused)
        );
      end
    end
  endgenerate
endmodule

module pp_accum_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_next;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [CW-1:0]  cnt_r;
  logic [2*N-1:0] acc_r;
  logic [2*N-1:0] row_s;
  logic [2*N-1:0] sum_s;
  logic [2*N-1:0] product_r;
  logic           last_row_s;
  logic           busy_r;
  logic           done_r;

  // Row k is the multiplicand gated by multiplier bit k, placed at weight 2^k.
  function automatic logic [2*N-1:0] pp_row(
    input logic [N-1:0]  m,
    input logic          sel,
    input logic [CW-1:0] sh
  );
    logic [2*N-1:0] ext;
    ext = {{N{1'b0}}, m & {N{sel}}};
    return ext << sh;
  endfunction

  assign row_s      = pp_row(a_r, b_r[cnt_r], cnt_r);
  assign last_row_s = (cnt_r == LAST_ROW);

  pp_ripple_add #(.W(2 * N)) u_add (
    .x   (acc_r),
    .y   (row_s),
    .sum (sum_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic; RUN always lasts exactly N cycles.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_row_s) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, row accumulation and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= {N{1'b0}};
      b_r       <= {N{1'b0}};
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*N){1'b0}};
      product_r <= {(2*N){1'b0}};
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_next != IDLE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            cnt_r <= {CW{1'b0}};
            acc_r <= {(2*N){1'b0}};
          end
        end
        RUN: begin
          acc_r <= sum_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_row_s) begin
            product_r <= sum_s;
            done_r    <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;
endmodule

// File: tb/tb_pp_accum_mult.sv
// Directed bench for pp_accum_mult (N=8) with a short random sweep.

module tb_pp_accum_mult;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  pp_accum_mult #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full operation; operands are scrambled after acceptance.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp, input logic [15:0] prev);
    int cyc;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0; a = ~av; b = ~bv;
    cyc = 1;
    check({tag, " busy_run"}, busy, 1);
    check({tag, " done_early"}, done, 0);
    check({tag, " prod_hold"}, product, prev);
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, " done"}, done, 1);
    check({tag, " latency"}, cyc, 9);
    check({tag, " product"}, product, exp);
    check({tag, " busy_done"}, busy, 1);
    tick();
    check({tag, " done_1cyc"}, done, 0);
    check({tag, " busy_idle"}, busy, 0);
  endtask

  initial begin
    int cyc;
    int gap;
    logic seen;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] last_prod;

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset product", product, 0);
    rst = 1'b0;
    tick();
    check("idle busy", busy, 0);

    run_op("max", 8'hFF, 8'hFF, 16'hFE01, 16'h0000);
    run_op("shift", 8'h80, 8'h02, 16'h0100, 16'hFE01);
    run_op("zero", 8'h00, 8'hA5, 16'h0000, 16'h0100);

    // Start requests during RUN and DONE are ignored.
    a = 8'd3; b = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; a = 8'd7; b = 8'd7;
    tick();
    start = 1'b0;
    cyc = 4;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("ign done", done, 1);
    check("ign latency", cyc, 9);
    check("ign product", product, 16'h000F);
    start = 1'b1; a = 8'd7;
    tick();
    start = 1'b0;
    check("ign drop done", done, 0);
    check("ign drop busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | busy | done;
    end
    check("ign no second op", seen, 0);
    check("ign product hold", product, 16'h000F);

    // Reset in the middle of RUN aborts with no done pulse.
    a = 8'h12; b = 8'h34; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort product", product, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | done;
    end
    check("abort no done", seen, 0);

    run_op("after_rst", 8'h12, 8'h34, 16'h03A8, 16'h0000);

    // Back-to-back with start held high.
    a = 8'h0C; b = 8'h0D; start = 1'b1;
    tick();
    a = 8'h10; b = 8'h10;
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("b2b op1 done", done, 1);
    check("b2b op1 latency", cyc, 9);
    check("b2b op1 product", product, 16'h009C);
    gap = 0;
    tick();
    gap++;
    while (done !== 1'b1 && gap < 30) begin
      if (gap == 5) begin
        check("b2b mid product", product, 16'h009C);
        check("b2b mid busy", busy, 1);
      end
      tick();
      gap++;
    end
    start = 1'b0;
    check("b2b op2 done", done, 1);
    check("b2b spacing", gap, 10);
    check("b2b op2 product", product, 16'h0100);
    tick();
    check("b2b done clear", done, 0);
    last_prod = 16'h0100;
    tick();

    // Random pairs with random idle gaps.
    for (int k = 0; k < 25; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        tick();
      end
      run_op("rand", ra, rb, {8'h00, ra} * {8'h00, rb}, last_prod);
      last_prod = {8'h00, ra} * {8'h00, rb};
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
